// File: rtl/watchdog_pkg.sv
// -----------------------------------------------------------------------------
// watchdog_pkg
// Shared definitions for the watchdog block:
//   - wd_state_t : FSM state encoding (IDLE=0, RUN=1, EXP=2)
//   - ADDR_CFG / ADDR_RLD : register select values on the 1-bit addr bus
//   - CFG_* : bit positions of the fields inside the CFG register
// -----------------------------------------------------------------------------
package watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EXP  = 2'd2
    } wd_state_t;

    localparam logic ADDR_CFG = 1'b0;
    localparam logic ADDR_RLD = 1'b1;

    // CFG register layout: {en, window[14:0], timeout[15:0]}
    localparam int CFG_TO_LSB  = 0;
    localparam int CFG_TO_MSB  = 15;
    localparam int CFG_WIN_LSB = 16;
    localparam int CFG_WIN_MSB = 30;
    localparam int CFG_EN_BIT  = 31;

endpackage

// File: rtl/watchdog.sv
// -----------------------------------------------------------------------------
// watchdog
// Tick-driven watchdog timer with a two-register IO interface.
//   CFG (addr 0): write loads {en, window, timeout} and restarts the count;
//                 read returns {en, window[14:0], timeout[15:0]}.
//   RLD (addr 1): write in RUN clears the elapsed count (data ignored);
//                 read returns {14'b0, state[1:0], elapsed[15:0]}.
// When elapsed reaches timeout the block enters EXP and pulses trig once.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   stb      in   IO strobe
//   we       in   write enable
//   addr     in   register select (0 = CFG, 1 = RLD)
//   tick     in   time-base enable, one-cycle pulse
//   data_in  in   32-bit write data
//   data_out out  32-bit combinational read data (0 unless a read is active)
//   trig     out  registered one-cycle expiry pulse
//   ack      out  mirrors stb (zero wait states)
//
// Parameter TW: width of the timeout/elapsed counters (at most 16).
// Optional feature macro WATCHDOG_WINDOW_EN: enables the window register;
// a reload arriving while elapsed < window is treated as an expiry.
// -----------------------------------------------------------------------------
module watchdog
    import watchdog_pkg::*;
#(
    parameter int TW = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic        tick,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        trig,
    output logic        ack
);

    wd_state_t      state;
    logic           en;
    logic [TW-1:0]  timeout;
    logic [TW-1:0]  elapsed;
    logic [TW-1:0]  elapsed_inc;
    logic [14:0]    window_q;
    logic           cfg_wr;
    logic           rld_wr;

    assign cfg_wr      = stb && we && (addr == ADDR_CFG);
    assign rld_wr      = stb && we && (addr == ADDR_RLD);
    assign elapsed_inc = elapsed + 1'b1;
    assign ack         = stb;

`ifndef WATCHDOG_WINDOW_EN
    // Window field is not stored in this build; it always reads back as 0.
    logic unused_window_bits;
    assign unused_window_bits = ^data_in[CFG_WIN_MSB:CFG_WIN_LSB];
    assign window_q = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            en      <= 1'b0;
            timeout <= '0;
            elapsed <= '0;
            trig    <= 1'b0;
`ifdef WATCHDOG_WINDOW_EN
            window_q <= '0;
`endif
        end else begin
            trig <= 1'b0;
            // Register writes take priority over a coincident tick.
            if (cfg_wr) begin
                en      <= data_in[CFG_EN_BIT];
                timeout <= data_in[CFG_TO_LSB +: TW];
                elapsed <= '0;
`ifdef WATCHDOG_WINDOW_EN
                window_q <= data_in[CFG_WIN_MSB:CFG_WIN_LSB];
`endif
                if (data_in[CFG_EN_BIT] && (data_in[CFG_TO_LSB +: TW] != '0))
                    state <= RUN;
                else
                    state <= IDLE;
            end else if (rld_wr) begin
                if (state == RUN) begin
`ifdef WATCHDOG_WINDOW_EN
                    // Reloading too early counts as a failure of the watched task.
                    if (16'(elapsed) < {1'b0, window_q}) begin
                        state <= EXP;
                        trig  <= 1'b1;
                    end else begin
                        elapsed <= '0;
                    end
`else
                    elapsed <= '0;
`endif
                end
            end else if (tick && (state == RUN)) begin
                elapsed <= elapsed_inc;
                if (elapsed_inc == timeout) begin
                    state <= EXP;
                    trig  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (stb && !we) begin
            if (addr == ADDR_CFG)
                data_out = {en, window_q, 16'(timeout)};
            else
                data_out = {14'b0, state, 16'(elapsed)};
        end
    end

endmodule
